mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Arbitrates multiple packetizer clients onto the single mem→core packet bus (icache = client 0, dcache = client 1).
- Provides lock-aware round-robin ownership with a registered grant and a registered bus output.
- Sits directly downstream of the icache/dcache packetizers and drives the packet bus clock domain.

Parameters:
- N_CLIENTS, 2, number of requesting packetizers
- N_LOG, 1, ceil(log2(N_CLIENTS)), minimum 1
- PACKET_WIDTH, 8, bus width in bits
- LOCK_TIMEOUT, 1023, maximum consecutive owned cycles before forced release (optional feature only)
- TO_BITS, 10, timeout counter width; must satisfy 2^TO_BITS > LOCK_TIMEOUT

Ports:
- clk  in  1  packet-bus clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_i  in  N_CLIENTS  per-client packet request
- lock_i  in  N_CLIENTS  per-client hold-ownership (multi-packet payload in progress)
- mask_i  in  N_CLIENTS  1 = client excluded from new grants
- packet_i  in  N_CLIENTS*PACKET_WIDTH  client packets; client k occupies bits [k*PACKET_WIDTH +: PACKET_WIDTH]
- grant_o  out  N_CLIENTS  registered one-hot grant
- grant_index_o  out  N_LOG  index of owner; 0 when idle
- bus_o  out  PACKET_WIDTH  registered packet bus
- bus_valid_o  out  1  bus_o carries a packet this cycle
- timeout_err_o  out  1  sticky forced-release flag

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, rr_ptr=0, timeout counter 0.
- FSM states: IDLE, OWNED.
- Eligibility: eligible[k] = req_i[k] & ~mask_i[k].
- IDLE:
  - If any client is eligible, select the first eligible index searching upward from rr_ptr with wrap-around.
  - Next cycle: grant_o is one-hot for that client, grant_index_o = its index, state = OWNED.
  - Otherwise stay IDLE with grant_o = 0.
- OWNED(o):
  - Retain ownership while lock_i[o] is high, regardless of req_i[o] and mask_i[o].
  - Release when lock_i[o] is low. On release, rr_ptr = o+1 (mod N_CLIENTS), and re-arbitration occurs in the same cycle with the updated pointer, excluding o.
    - If another client is eligible, its grant appears next cycle with no idle bubble.
    - Otherwise, if o is still eligible, o is re-granted.
    - Otherwise go to IDLE.
  - The excluding-o rule guarantees alternation under contention.
- Bus datapath:
  - Each cycle, if grant_o[k]: bus_o <= packet_i[k], bus_valid_o <= 1.
  - Otherwise bus_o <= 0, bus_valid_o <= 0.
  - Latency: packet sampled in a grant cycle appears one cycle later.
- Simultaneous requests: rr_ptr resolves the winner. After reset, client 0 wins.
- Mask asserted on the current owner does not revoke ownership; it only blocks re-grant.
- Request deasserted while lock is held: ownership is kept (lock dominates).
- grant_o is never multi-hot. The bench asserts this.

Optional Feature:
- Macro: MEM_BUS_ARB_LOCK_TIMEOUT_EN.
- Enabled:
  - A TO_BITS counter increments each OWNED cycle and clears on any ownership change or IDLE.
  - When it reaches LOCK_TIMEOUT, ownership is force-released next cycle as if lock_i were low.
  - timeout_err_o is set and stays sticky until reset.
- Disabled: no counter is built, timeout_err_o is tied to 0, and lock is held indefinitely.

Decomposition:
- Shared package mem_bus_pkg:
  - typedef arb_state_t {IDLE, OWNED}
  - constants MEM_BUS_ICACHE_ID=0, MEM_BUS_DCACHE_ID=1, MEM_BUS_PACKET_WIDTH=8
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: eligible vector, start pointer.
  - Outputs: one-hot vector, index, any-valid.
  - Used for both the IDLE grant and the release re-arbitration paths.

Test Plan:
- Reset with req_i=2'b11 asserted → grant_o=0, bus_o=0 during reset; first cycle after reset release grant_o=2'b01; next cycle bus_o=packet_i[7:0], bus_valid_o=1.
- Client 1 req+lock for 36 cycles with packets 0x01..0x24; client 0 requests at cycle 5 → grant stays 2'b10 for all 36 cycles; bus_o carries 0x01..0x24 in order, one cycle delayed; grant_o=2'b01 the cycle after lock drops, with no bubble.
- Both clients request continuously with lock low → grant_o alternates 01,10,01,10; bus_valid_o stays 1.
- mask_i=2'b01 with req_i=2'b11 from IDLE → client 1 granted; clear mask → client 0 granted on the next release.
- Owner drops req_i while holding lock_i=1 → ownership kept; release only when lock falls; then IDLE with grant_o=0 and bus_valid_o=0 one cycle later.
- With MEM_BUS_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8: client 0 holds lock forever → forced release after 8 owned cycles; timeout_err_o=1 and sticky; client 1 granted next; assert rst_n mid-ownership → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the mem->core packet bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int MEM_BUS_ICACHE_ID    = 0;
  localparam int MEM_BUS_DCACHE_ID    = 1;
  localparam int MEM_BUS_PACKET_WIDTH = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Client-side request/packet bundle and arbiter-side grant/bus outputs.
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int N_CLIENTS    = 2,
  parameter int N_LOG        = 1,
  parameter int PACKET_WIDTH = MEM_BUS_PACKET_WIDTH
);

  logic [N_CLIENTS-1:0]              req_i;
  logic [N_CLIENTS-1:0]              lock_i;
  logic [N_CLIENTS-1:0]              mask_i;
  logic [N_CLIENTS*PACKET_WIDTH-1:0] packet_i;
  logic [N_CLIENTS-1:0]              grant_o;
  logic [N_LOG-1:0]                  grant_index_o;
  logic [PACKET_WIDTH-1:0]           bus_o;
  logic                              bus_valid_o;
  logic                              timeout_err_o;

  modport master (
    output req_i, lock_i, mask_i, packet_i,
    input  grant_o, grant_index_o, bus_o, bus_valid_o, timeout_err_o
  );

  modport slave (
    input  req_i, lock_i, mask_i, packet_i,
    output grant_o, grant_index_o, bus_o, bus_valid_o, timeout_err_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above start, wrapping.
module rr_pick #(
  parameter int N_CLIENTS = 2,
  parameter int N_LOG     = 1
) (
  input  logic [N_CLIENTS-1:0] eligible,
  input  logic [N_LOG-1:0]     start,
  output logic [N_CLIENTS-1:0] onehot,
  output logic [N_LOG-1:0]     index,
  output logic                 any_valid
);

  logic [N_LOG:0]   sum_s;
  logic [N_LOG-1:0] cand_s;
  logic             take_s;

  // Walk candidates in priority order; the first eligible one claims the grant.
  always_comb begin
    onehot    = {N_CLIENTS{1'b0}};
    index     = {N_LOG{1'b0}};
    any_valid = 1'b0;
    sum_s     = {(N_LOG+1){1'b0}};
    cand_s    = {N_LOG{1'b0}};
    take_s    = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      sum_s  = {1'b0, start} + (N_LOG+1)'(i);
      sum_s  = (sum_s >= (N_LOG+1)'(N_CLIENTS)) ? sum_s - (N_LOG+1)'(N_CLIENTS) : sum_s;
      cand_s = sum_s[N_LOG-1:0];
      take_s = ~any_valid & eligible[cand_s];
      onehot[cand_s] = onehot[cand_s] | take_s;
      index     = take_s ? cand_s : index;
      any_valid = any_valid | take_s;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Lock-aware round-robin arbiter for the icache/dcache packetizers onto the packet bus.
// Optional forced lock release: define MEM_BUS_ARB_LOCK_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N_CLIENTS    = 2,
  parameter int N_LOG        = 1,
  parameter int PACKET_WIDTH = MEM_BUS_PACKET_WIDTH,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int TO_BITS      = 10
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  if ((2 ** TO_BITS) <= LOCK_TIMEOUT) begin : g_to_bits_check
    $error("TO_BITS too narrow for LOCK_TIMEOUT");
  end

  arb_state_t              state_r;
  logic [N_LOG-1:0]        owner_r;
  logic [N_LOG-1:0]        rr_ptr_r;
  logic [N_LOG-1:0]        next_ptr_s;
  logic [N_LOG-1:0]        pick_start_s;
  logic [N_LOG-1:0]        pick_index_s;
  logic [N_LOG-1:0]        grant_index_r;
  logic [N_CLIENTS-1:0]    eligible_s;
  logic [N_CLIENTS-1:0]    pick_elig_s;
  logic [N_CLIENTS-1:0]    pick_onehot_s;
  logic [N_CLIENTS-1:0]    grant_r;
  logic                    pick_any_s;
  logic                    timeout_hit_s;
  logic                    release_s;
  logic [PACKET_WIDTH-1:0] bus_sel_s;
  logic [PACKET_WIDTH-1:0] bus_r;
  logic                    bus_valid_r;

  assign eligible_s = bus.req_i & ~bus.mask_i;
  assign next_ptr_s = (owner_r == N_LOG'(N_CLIENTS - 1)) ? {N_LOG{1'b0}} : owner_r + N_LOG'(1);
  assign release_s  = (state_r == OWNED) && (!bus.lock_i[owner_r] || timeout_hit_s);

  // A releasing owner is excluded and the search restarts just above it.
  always_comb begin
    if (state_r == OWNED) begin
      pick_start_s = next_ptr_s;
      pick_elig_s  = eligible_s & ~grant_r;
    end else begin
      pick_start_s = rr_ptr_r;
      pick_elig_s  = eligible_s;
    end
  end

  rr_pick #(
    .N_CLIENTS (N_CLIENTS),
    .N_LOG     (N_LOG)
  ) u_pick (
    .eligible  (pick_elig_s),
    .start     (pick_start_s),
    .onehot    (pick_onehot_s),
    .index     (pick_index_s),
    .any_valid (pick_any_s)
  );

  // Ownership FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      owner_r       <= {N_LOG{1'b0}};
      rr_ptr_r      <= {N_LOG{1'b0}};
      grant_r       <= {N_CLIENTS{1'b0}};
      grant_index_r <= {N_LOG{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r       <= OWNED;
            owner_r       <= pick_index_s;
            grant_r       <= pick_onehot_s;
            grant_index_r <= pick_index_s;
          end else begin
            grant_r       <= {N_CLIENTS{1'b0}};
            grant_index_r <= {N_LOG{1'b0}};
          end
        end
        OWNED: begin
          if (release_s) begin
            rr_ptr_r <= next_ptr_s;
            if (pick_any_s) begin
              owner_r       <= pick_index_s;
              grant_r       <= pick_onehot_s;
              grant_index_r <= pick_index_s;
            end else if (eligible_s[owner_r]) begin
              owner_r <= owner_r;
              grant_r <= grant_r;
            end else begin
              state_r       <= IDLE;
              owner_r       <= {N_LOG{1'b0}};
              grant_r       <= {N_CLIENTS{1'b0}};
              grant_index_r <= {N_LOG{1'b0}};
            end
          end else begin
            owner_r <= owner_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          owner_r       <= {N_LOG{1'b0}};
          grant_r       <= {N_CLIENTS{1'b0}};
          grant_index_r <= {N_LOG{1'b0}};
        end
      endcase
    end
  end

`ifdef MEM_BUS_ARB_LOCK_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_r;
  logic               timeout_err_r;

  // Counter value is the number of owned cycles already completed by the current owner.
  assign timeout_hit_s = (state_r == OWNED) && (to_cnt_r == TO_BITS'(LOCK_TIMEOUT - 1));

  // Owned-cycle counter and sticky forced-release flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r      <= {TO_BITS{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      to_cnt_r      <= (state_r == OWNED && !release_s) ? to_cnt_r + TO_BITS'(1) : {TO_BITS{1'b0}};
      timeout_err_r <= timeout_err_r | (timeout_hit_s & bus.lock_i[owner_r]);
    end
  end

  assign bus.timeout_err_o = timeout_err_r;
`else
  assign timeout_hit_s     = 1'b0;
  assign bus.timeout_err_o = 1'b0;
`endif

  // Grant is one-hot, so an AND-OR mux selects the owner's packet.
  always_comb begin
    bus_sel_s = {PACKET_WIDTH{1'b0}};
    for (int k = 0; k < N_CLIENTS; k++) begin
      bus_sel_s = bus_sel_s | (bus.packet_i[k*PACKET_WIDTH +: PACKET_WIDTH] & {PACKET_WIDTH{grant_r[k]}});
    end
  end

  // Registered bus stage: one cycle behind the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_r       <= {PACKET_WIDTH{1'b0}};
      bus_valid_r <= 1'b0;
    end else begin
      bus_r       <= bus_sel_s;
      bus_valid_r <= |grant_r;
    end
  end

  assign bus.grant_o       = grant_r;
  assign bus.grant_index_o = grant_index_r;
  assign bus.bus_o         = bus_r;
  assign bus.bus_valid_o   = bus_valid_r;

endmodule
